// File: rtl/mcac_pkg.sv
// Shared types and defaults for the MCAC channel-sequencing control unit.
package mcac_pkg;

  localparam int unsigned CU_NUM_CH_DEF     = 32;
  localparam int unsigned CU_NUM_STAGES_DEF = 8;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_WB   = 3'd3,
    ST_DONE = 3'd4
  } cu_state_e;

endpackage

// File: rtl/cu_stage_ring.sv
// One-hot stage strobe shifter: start loads stage 0, advance walks the bit out the top.
module cu_stage_ring #(
  parameter int unsigned NUM_STAGES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  advance,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  last
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      stage_en <= '0;
    end else if (start) begin
      stage_en <= NUM_STAGES'(1);
    end else if (advance) begin
      stage_en <= stage_en << 1;
    end
  end

  assign last = stage_en[NUM_STAGES-1];

endmodule

// File: rtl/mcac_cu_mc.sv
// MCAC control unit: sequences LOAD/RUN/WB per channel each frame.
// Optional CU_CH_MASK_EN adds a ch_mask port to skip disabled channels.
module mcac_cu_mc
  import mcac_pkg::*;
#(
  parameter int unsigned NUM_CH     = CU_NUM_CH_DEF,
  parameter int unsigned NUM_STAGES = CU_NUM_STAGES_DEF,
  parameter int unsigned CH_W       = $clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_sync,
  input  logic                  mode,
`ifdef CU_CH_MASK_EN
  input  logic [NUM_CH-1:0]     ch_mask,
`endif
  input  logic                  scan_in0,
  input  logic                  scan_en,
  output logic [CH_W-1:0]       ch_idx,
  output logic                  mode_q,
  output logic                  st_load,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  st_wb,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun,
  output logic                  scan_out0
);

  cu_state_e       state_q, state_d;
  logic [CH_W-1:0] ch_idx_d;
  logic            mode_d;
  logic            ring_start, ring_adv, ring_last;
  logic            unused_scan;

`ifdef CU_CH_MASK_EN
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CH_W:0]     first_ch, next_ch;

  // Lowest enabled channel at or above 'from'; MSB flags whether one exists.
  function automatic logic [CH_W:0] find_ch(input logic [NUM_CH-1:0] m, input int unsigned from);
    logic [CH_W:0] res;
    res = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if ((int unsigned'(i) >= from) && m[i]) res = {1'b1, CH_W'(i)};
    end
    return res;
  endfunction

  assign first_ch = find_ch(ch_mask, 0);
  assign next_ch  = find_ch(mask_q, int unsigned'(ch_idx) + 1);
`endif

  assign ring_start  = (state_q == ST_LOAD);
  assign ring_adv    = (state_q == ST_RUN);
  assign scan_out0   = 1'b0;
  assign unused_scan = scan_in0 ^ scan_en;

  cu_stage_ring #(.NUM_STAGES(NUM_STAGES)) u_ring (
    .clk     (clk),
    .reset   (reset),
    .start   (ring_start),
    .advance (ring_adv),
    .stage_en(stage_en),
    .last    (ring_last)
  );

  // Next-state and next-context logic.
  always_comb begin
    state_d  = state_q;
    ch_idx_d = ch_idx;
    mode_d   = mode_q;
`ifdef CU_CH_MASK_EN
    mask_d   = mask_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (frame_sync) begin
          mode_d   = mode;
          ch_idx_d = '0;
          state_d  = ST_LOAD;
`ifdef CU_CH_MASK_EN
          mask_d = ch_mask;
          if (first_ch[CH_W]) ch_idx_d = first_ch[CH_W-1:0];
          else                state_d  = ST_DONE;
`endif
        end
      end
      ST_LOAD: state_d = ST_RUN;
      ST_RUN:  if (ring_last) state_d = ST_WB;
      ST_WB: begin
`ifdef CU_CH_MASK_EN
        if (next_ch[CH_W]) begin
          ch_idx_d = next_ch[CH_W-1:0];
          state_d  = ST_LOAD;
        end else begin
          state_d = ST_DONE;
        end
`else
        if (ch_idx == CH_W'(NUM_CH - 1)) begin
          state_d = ST_DONE;
        end else begin
          ch_idx_d = ch_idx + CH_W'(1);
          state_d  = ST_LOAD;
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; strobes decode the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ch_idx     <= '0;
      mode_q     <= MODE_ENC;
      st_load    <= 1'b0;
      st_wb      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
`ifdef CU_CH_MASK_EN
      mask_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ch_idx     <= ch_idx_d;
      mode_q     <= mode_d;
      st_load    <= (state_d == ST_LOAD);
      st_wb      <= (state_d == ST_WB);
      busy       <= (state_d != ST_IDLE);
      frame_done <= (state_d == ST_DONE);
      overrun    <= overrun | (frame_sync & (state_q != ST_IDLE));
`ifdef CU_CH_MASK_EN
      mask_q     <= mask_d;
`endif
    end
  end

endmodule

// File: tb/tb_mcac_cu_mc.sv
// Directed bench for mcac_cu_mc with NUM_CH=4, NUM_STAGES=3.
module tb_mcac_cu_mc;

  logic       clk, reset, frame_sync, mode, scan_in0, scan_en;
  logic [3:0] ch_mask;
  logic [1:0] ch_idx;
  logic       mode_q, st_load, st_wb, busy, frame_done, overrun, scan_out0;
  logic [2:0] stage_en;
  logic [10:0] obs;
  int total, bad;

  mcac_cu_mc #(.NUM_CH(4), .NUM_STAGES(3)) dut (
    .clk(clk), .reset(reset), .frame_sync(frame_sync), .mode(mode),
`ifdef CU_CH_MASK_EN
    .ch_mask(ch_mask),
`endif
    .scan_in0(scan_in0), .scan_en(scan_en),
    .ch_idx(ch_idx), .mode_q(mode_q), .st_load(st_load), .stage_en(stage_en),
    .st_wb(st_wb), .busy(busy), .frame_done(frame_done), .overrun(overrun),
    .scan_out0(scan_out0)
  );

  assign obs = {ch_idx, mode_q, st_load, stage_en, st_wb, busy, frame_done, overrun};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected output vector in cycle c (1..21) after an accepted frame_sync.
  function automatic logic [10:0] exp_frame(input int c, input logic m, input logic ov);
    int k, ph;
    logic [1:0] ci;
    logic [2:0] se;
    logic ld, wb, dn;
    k = c - 1; ph = k % 5; se = '0; ld = 0; wb = 0; dn = 0;
    if (c == 21) begin
      ci = 2'd3; dn = 1'b1;
    end else begin
      ci = 2'(k / 5);
      ld = (ph == 0);
      wb = (ph == 4);
      if (ph >= 1 && ph <= 3) se = 3'(1 << (ph - 1));
    end
    return {ci, m, ld, se, wb, 1'b1, dn, ov};
  endfunction

  function automatic logic [10:0] exp_idle(input logic [1:0] ci, input logic m, input logic ov);
    return {ci, m, 7'b0, ov};
  endfunction

  task automatic do_reset();
    reset = 1'b0; frame_sync = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; frame_sync = 1'b1; mode = 1'b1; scan_en = 1'b1; scan_in0 = 1'b1;
    tick();
    total++;
    if (obs !== 11'b0 || scan_out0 !== 1'b0) begin
      bad++; $display("FAIL reset_state obs=%b scan_out0=%b want 0", obs, scan_out0);
    end
    reset = 1'b1; frame_sync = 1'b0; scan_en = 1'b0; scan_in0 = 1'b0;
    tick();
    total++;
    if (obs !== 11'b0) begin
      bad++; $display("FAIL reset_discards_sync obs=%b want 0", obs);
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    mode = 1'b1; frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      total++;
      if (obs !== exp_frame(c, 1'b1, 1'b0)) begin
        bad++; $display("FAIL single_frame c=%0d obs=%b want %b", c, obs, exp_frame(c, 1'b1, 1'b0));
      end
      if (c == 3) mode = 1'b0;
      scan_en = c[0]; scan_in0 = c[1];
      tick();
    end
    total++;
    if (obs !== exp_idle(2'd3, 1'b1, 1'b0) || scan_out0 !== 1'b0) begin
      bad++; $display("FAIL single_frame_idle obs=%b want %b", obs, exp_idle(2'd3, 1'b1, 1'b0));
    end
    scan_en = 1'b0; scan_in0 = 1'b0;
  endtask

  task automatic test_overrun();
    do_reset();
    mode = 1'b1; frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      total++;
      if (obs !== exp_frame(c, 1'b1, c >= 11)) begin
        bad++; $display("FAIL overrun c=%0d obs=%b want %b", c, obs, exp_frame(c, 1'b1, c >= 11));
      end
      frame_sync = (c == 10);
      tick();
    end
    frame_sync = 1'b0;
    tick();
    total++;
    if (obs !== exp_idle(2'd3, 1'b1, 1'b1)) begin
      bad++; $display("FAIL overrun_sticky obs=%b want %b", obs, exp_idle(2'd3, 1'b1, 1'b1));
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    mode = 1'b1; frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      total++;
      if (obs !== exp_frame(c, 1'b1, 1'b0)) begin
        bad++; $display("FAIL mid_reset_pre c=%0d obs=%b want %b", c, obs, exp_frame(c, 1'b1, 1'b0));
      end
      if (c == 8) begin reset = 1'b0; frame_sync = 1'b1; end
      tick();
    end
    total++;
    if (obs !== 11'b0) begin
      bad++; $display("FAIL mid_reset_c9 obs=%b want 0", obs);
    end
    reset = 1'b1; frame_sync = 1'b0; mode = 1'b0;
    tick();
    total++;
    if (obs !== 11'b0) begin
      bad++; $display("FAIL mid_reset_idle obs=%b want 0", obs);
    end
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      total++;
      if (obs !== exp_frame(c, 1'b0, 1'b0)) begin
        bad++; $display("FAIL mid_reset_frame c=%0d obs=%b want %b", c, obs, exp_frame(c, 1'b0, 1'b0));
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mode = 1'b0; frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      total++;
      if (obs !== exp_frame(c, 1'b0, 1'b0)) begin
        bad++; $display("FAIL b2b_first c=%0d obs=%b want %b", c, obs, exp_frame(c, 1'b0, 1'b0));
      end
      tick();
    end
    total++;
    if (obs !== exp_idle(2'd3, 1'b0, 1'b0)) begin
      bad++; $display("FAIL b2b_gap obs=%b want %b", obs, exp_idle(2'd3, 1'b0, 1'b0));
    end
    mode = 1'b1; frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      total++;
      if (obs !== exp_frame(c, 1'b1, 1'b0)) begin
        bad++; $display("FAIL b2b_second c=%0d obs=%b want %b", c, obs, exp_frame(c, 1'b1, 1'b0));
      end
      frame_sync = (c == 21);
      tick();
    end
    frame_sync = 1'b0;
    total++;
    if (obs !== exp_idle(2'd3, 1'b1, 1'b1)) begin
      bad++; $display("FAIL b2b_done_sync obs=%b want %b", obs, exp_idle(2'd3, 1'b1, 1'b1));
    end
    tick();
    total++;
    if (obs !== exp_idle(2'd3, 1'b1, 1'b1)) begin
      bad++; $display("FAIL b2b_not_started obs=%b want %b", obs, exp_idle(2'd3, 1'b1, 1'b1));
    end
  endtask

`ifdef CU_CH_MASK_EN
  task automatic test_mask();
    logic [10:0] e;
    int k, ph;
    do_reset();
    ch_mask = 4'b1010; mode = 1'b0; frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0; ch_mask = 4'b1111;
    for (int c = 1; c <= 11; c++) begin
      k = c - 1; ph = k % 5;
      if (c == 11) e = {2'd3, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0};
      else e = {(k < 5) ? 2'd1 : 2'd3, 1'b0, ph == 0,
                (ph >= 1 && ph <= 3) ? 3'(1 << (ph - 1)) : 3'b000, ph == 4, 1'b1, 1'b0, 1'b0};
      total++;
      if (obs !== e) begin
        bad++; $display("FAIL mask_1010 c=%0d obs=%b want %b", c, obs, e);
      end
      tick();
    end
    total++;
    if (obs !== exp_idle(2'd3, 1'b0, 1'b0)) begin
      bad++; $display("FAIL mask_1010_idle obs=%b want %b", obs, exp_idle(2'd3, 1'b0, 1'b0));
    end
    ch_mask = 4'b0000; frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0; ch_mask = 4'b1111;
    total++;
    if (obs !== {2'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL mask_zero_done obs=%b want 00000000110", obs);
    end
    tick();
    total++;
    if (obs !== exp_idle(2'd0, 1'b0, 1'b0)) begin
      bad++; $display("FAIL mask_zero_idle obs=%b want %b", obs, exp_idle(2'd0, 1'b0, 1'b0));
    end
  endtask
`endif

  initial begin
    total = 0; bad = 0;
    reset = 1'b0; frame_sync = 1'b0; mode = 1'b0;
    scan_in0 = 1'b0; scan_en = 1'b0; ch_mask = 4'b1111;
    tick();
    test_reset();
    test_single_frame();
    test_overrun();
    test_mid_reset();
    test_back_to_back();
`ifdef CU_CH_MASK_EN
    test_mask();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
